fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default WORD_LEN from defines (32), meaning instruction and PC width.
REQ-002 The block SHALL have parameter QDEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-003 The block SHALL have parameter MAX_OUTST, default 2, meaning maximum outstanding memory requests (1..QDEPTH).
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid, output, 1, fetch request valid.
REQ-008 The block SHALL have port req_ready, input, 1, memory accepts request.
REQ-009 The block SHALL have port req_addr, output, WORD_LEN, fetch address.
REQ-010 The block SHALL have port rsp_valid, input, 1, in-order response valid; it has no backpressure.
REQ-011 The block SHALL have port rsp_data, input, WORD_LEN, fetched instruction.
REQ-012 The block SHALL have port redirect, input, 1, taken branch / flush.
REQ-013 The block SHALL have port redirect_pc, input, WORD_LEN, new fetch address.
REQ-014 The block SHALL have port freeze, input, 1, hazard stall; the consumer does not take an instruction.
REQ-015 The block SHALL have ports inst_valid (output, 1), inst (output, WORD_LEN) and inst_pc (output, WORD_LEN), giving the queue head.

Function
REQ-016 A request SHALL be accepted when req_valid && req_ready; req_addr SHALL then advance by 4 the next cycle.
REQ-017 req_valid SHALL be high only when outst < MAX_OUTST, outst + count < QDEPTH and redirect is low.
REQ-018 Under REQ-017 the queue SHALL never overflow.
REQ-019 Each accepted request SHALL push its address into a PC-tag FIFO of depth MAX_OUTST.
REQ-020 Each non-dropped response SHALL enqueue {rsp_data, tag-FIFO head} and pop the tag FIFO.
REQ-021 The enqueued entry SHALL become visible on inst_valid the next cycle (latency 1, no bypass).
REQ-022 A dequeue SHALL occur when inst_valid && !freeze && !redirect.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged, including when the queue is full.
REQ-024 Read and write pointers SHALL wrap modulo QDEPTH.
REQ-025 On redirect, the next cycle SHALL have: count=0, inst_valid=0, req_addr=redirect_pc, tag FIFO emptied, drop=outst (including a request accepted in the redirect cycle), and outst recomputed accordingly.
REQ-026 While drop>0, each rsp_valid SHALL decrement drop and outst and SHALL NOT enqueue.
REQ-027 req_valid MAY reassert while drop>0.
REQ-028 A response arriving in the redirect cycle SHALL be discarded and counted against the drop total.
REQ-029 Back-to-back redirects SHALL each restart fetch; the last redirect SHALL win.
REQ-030 outst SHALL be incremented on request accept and decremented on response, both in the same cycle when both occur.
REQ-031 An rsp_valid with outst=0 SHALL be ignored.
REQ-032 freeze SHALL NOT stop fetching; only dequeue is held.

Reset
REQ-033 On rstn low, the block SHALL asynchronously set: req_addr=RESET_PC, req_valid=0, inst_valid=0, inst=0, inst_pc=0, count=0, outst=0, drop=0, and all pointers 0.
REQ-034 On the first cycle after rstn rises, req_valid SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL discard all queued and in-flight state; responses arriving after release with outst=0 SHALL be ignored.

Structure
REQ-036 FETCH_QDEPTH_DEF and FETCH_OUTST_DEF SHALL be added to defines; WORD_LEN SHALL be taken from defines.
REQ-037 The queue and the tag FIFO SHALL both instantiate one sub-module, sync_fifo (parametrised width and depth, push/pop/full/empty/count).

Verification
REQ-038 Reset release with req_ready=1 and 1-cycle memory -> requests at 0x0, 0x4, 0x8, ...; first inst_valid in cycle 3 with inst_pc=0x0.
REQ-039 freeze=1 held for 10 cycles -> count saturates at 4, req_valid=0, no overflow; freeze=0 -> 4 consecutive dequeues in PC order.
REQ-040 redirect to 0x100 with 2 requests outstanding -> next 2 responses dropped; first dequeued inst_pc=0x100.
REQ-041 redirect in the same cycle as a request accept and a response -> drop count correct; no stale instruction appears.
REQ-042 req_ready toggling 1/0 randomly for 200 cycles against a reference PC model -> instruction stream identical, outst <= MAX_OUTST.
REQ-043 rstn pulsed low with 2 requests outstanding -> all outputs at reset values immediately; late responses ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared defaults and types for the instruction fetch queue.
//   WORD_LEN_DEF      : instruction / PC width
//   FETCH_QDEPTH_DEF  : default instruction queue depth
//   FETCH_OUTST_DEF   : default number of outstanding memory requests
//   INST_BYTES        : PC increment per fetched instruction
//   rsp_act_e         : what happens to a memory response this cycle
//   ptr_width()       : pointer width for a FIFO of a given depth (min 1 bit)
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int WORD_LEN_DEF     = 32;
   localparam int FETCH_QDEPTH_DEF = 4;
   localparam int FETCH_OUTST_DEF  = 2;
   localparam int INST_BYTES       = 4;

   // A response is either absent/ignored, thrown away (stale after a
   // redirect), or written into the instruction queue.
   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,
      RSP_DROP = 2'd1,
      RSP_ENQ  = 2'd2
   } rsp_act_e;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy and synchronous flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Read data is the current head (valid while empty_o is low).
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   flush_i     : empty the FIFO at the next edge (wins over push/pop)
//   push_i      : write wdata_i
//   wdata_i     : data to write
//   pop_i       : remove the head entry
//   rdata_o     : head entry
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
//   count_o     : number of entries held
// -----------------------------------------------------------------------------
module sync_fifo
   import fetch_queue_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             wdata_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Explicit wrap so non-power-of-two depths also work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every variable gets a default before any condition, so no path
      // leaves one unassigned and no latch is inferred.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);

      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; contents are only observable
   // behind a non-zero count, which is reset, so clearing it buys nothing.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch front end: issues sequential fetch requests, tags each
// with its PC, pairs in-order responses with those tags and buffers the
// resulting {instruction, pc} entries for the decode stage. A redirect
// flushes the queue, restarts fetch at redirect_pc and discards the
// responses of every request still in flight.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   req_valid/req_ready  : fetch request handshake
//   req_addr             : fetch address
//   rsp_valid/rsp_data   : in-order memory response (no backpressure)
//   redirect/redirect_pc : taken branch / flush and new fetch address
//   freeze               : consumer stalls; fetching continues
//   inst_valid/inst/inst_pc : queue head presented to the consumer
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int                  WORD_LEN  = WORD_LEN_DEF,
   parameter int                  QDEPTH    = FETCH_QDEPTH_DEF,
   parameter int                  MAX_OUTST = FETCH_OUTST_DEF,
   parameter logic [WORD_LEN-1:0] RESET_PC  = '0
) (
   input  logic                clk,
   input  logic                rstn,
   output logic                req_valid,
   input  logic                req_ready,
   output logic [WORD_LEN-1:0] req_addr,
   input  logic                rsp_valid,
   input  logic [WORD_LEN-1:0] rsp_data,
   input  logic                redirect,
   input  logic [WORD_LEN-1:0] redirect_pc,
   input  logic                freeze,
   output logic                inst_valid,
   output logic [WORD_LEN-1:0] inst,
   output logic [WORD_LEN-1:0] inst_pc
);

   localparam int CNT_W = $clog2(QDEPTH + 1);
   localparam int OUT_W = $clog2(MAX_OUTST + 1);
   // Outstanding + queued can reach 2*QDEPTH transiently in the sum.
   localparam int SUM_W = CNT_W + 1;

   // Architectural state
   logic [WORD_LEN-1:0] addr_q, addr_d;
   logic [OUT_W-1:0]    outst_q, outst_d;   // requests accepted, response pending
   logic [OUT_W-1:0]    drop_q, drop_d;     // of those, responses to discard
   logic                run_q;              // low only in the cycle after reset

   // Handshake / control
   logic                accept;
   rsp_act_e            rsp_act;
   logic [SUM_W-1:0]    occupancy;

   // Instruction queue: {instruction, pc}
   logic                   q_push, q_pop, q_flush;
   logic                   q_full, q_empty;
   logic [CNT_W-1:0]       q_count;
   logic [2*WORD_LEN-1:0]  q_wdata, q_rdata;

   // PC tag FIFO: one entry per non-dropped outstanding request
   logic                t_push, t_pop, t_flush;
   logic                t_full, t_empty;
   logic [OUT_W-1:0]    t_count;
   logic [WORD_LEN-1:0] t_rdata;

   always_comb begin
      // Reserving room for every in-flight response guarantees no overflow.
      occupancy = SUM_W'(outst_q) + SUM_W'(q_count);
      req_valid = run_q
               && (outst_q < OUT_W'(MAX_OUTST))
               && (occupancy < SUM_W'(QDEPTH))
               && !redirect;
      accept    = req_valid && req_ready;

      // Responses with nothing outstanding are spurious and ignored. A
      // response in the redirect cycle belongs to the old stream.
      rsp_act = RSP_NONE;
      if (rsp_valid && (outst_q != '0)) begin
         rsp_act = (redirect || (drop_q != '0)) ? RSP_DROP : RSP_ENQ;
      end

      outst_d = outst_q;
      if (accept)              outst_d = outst_d + OUT_W'(1);
      if (rsp_act != RSP_NONE) outst_d = outst_d - OUT_W'(1);

      // After a redirect every remaining in-flight response is stale.
      drop_d = drop_q;
      if (redirect)                  drop_d = outst_d;
      else if (rsp_act == RSP_DROP)  drop_d = drop_q - OUT_W'(1);

      addr_d = addr_q;
      if (redirect)    addr_d = redirect_pc;
      else if (accept) addr_d = addr_q + WORD_LEN'(INST_BYTES);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_q  <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
         run_q   <= 1'b1;
      end
   end

   assign req_addr = addr_q;

   // Tag FIFO bookkeeping
   assign t_push  = accept;
   assign t_pop   = (rsp_act == RSP_ENQ);
   assign t_flush = redirect;

   sync_fifo #(
      .WIDTH (WORD_LEN),
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (t_flush),
      .push_i  (t_push),
      .wdata_i (addr_q),
      .pop_i   (t_pop),
      .rdata_o (t_rdata),
      .full_o  (t_full),
      .empty_o (t_empty),
      .count_o (t_count)
   );

   // Instruction queue: the registered count gives the one-cycle
   // enqueue-to-visible latency with no bypass.
   assign q_push  = (rsp_act == RSP_ENQ);
   assign q_wdata = {rsp_data, t_rdata};
   assign q_pop   = inst_valid && !freeze && !redirect;
   assign q_flush = redirect;

   sync_fifo #(
      .WIDTH (2 * WORD_LEN),
      .DEPTH (QDEPTH)
   ) u_inst_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (q_flush),
      .push_i  (q_push),
      .wdata_i (q_wdata),
      .pop_i   (q_pop),
      .rdata_o (q_rdata),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   // Head outputs read as zero whenever nothing valid is held, which also
   // gives the required zero values during reset.
   assign inst_valid = !q_empty;
   assign inst       = q_empty ? '0 : q_rdata[2*WORD_LEN-1:WORD_LEN];
   assign inst_pc    = q_empty ? '0 : q_rdata[WORD_LEN-1:0];

   // Status flags not needed by the control logic.
   logic unused_status;
   assign unused_status = ^{q_full, t_full, t_empty, t_count};

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Randomised bench for fetch_queue. The reference model keeps the fetch
// stream as queues: in-flight requests (with a stale mark after redirects),
// the instruction queue, and a memory with in-order random latency.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int          W   = 32;
   localparam int          QD  = 4;
   localparam int          MO  = 2;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_addr;
   logic          rsp_valid;
   logic [W-1:0]  rsp_data;
   logic          redirect;
   logic [W-1:0]  redirect_pc;
   logic          freeze;
   logic          inst_valid;
   logic [W-1:0]  inst;
   logic [W-1:0]  inst_pc;

   always #5 clk = ~clk;

   fetch_queue #(
      .WORD_LEN  (W),
      .QDEPTH    (QD),
      .MAX_OUTST (MO),
      .RESET_PC  (RPC)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .freeze      (freeze),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc)
   );

   typedef struct { logic [31:0] pc;   bit          stale; } flight_t;
   typedef struct { logic [31:0] data; logic [31:0] pc;    } entry_t;
   typedef struct { logic [31:0] addr; int          due;   } mem_t;

   flight_t     infl[$];
   entry_t      iq[$];
   mem_t        mem_q[$];
   logic [31:0] m_pc;
   bit          m_started;
   int          cyc;
   int          lat_min = 1;
   int          lat_max = 1;
   int          last_due = 0;
   bit          stray_en = 1'b0;
   int          stray_mod = 5;
   int          serial = 0;
   bit          from_mem;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_pc0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = RPC;
      m_started = 1'b0;
      infl.delete();
      iq.delete();
   endtask

   task automatic drive_rsp();
      from_mem  = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         serial++;
         rsp_valid = 1'b1;
         rsp_data  = {serial[7:0], mem_q[0].addr[23:0]};
         from_mem  = 1'b1;
      end else if (stray_en && mem_q.size() == 0 && $urandom_range(0, stray_mod) == 0) begin
         rsp_valid = 1'b1;
         rsp_data  = $urandom;
      end
   endtask

   // One clock cycle: drive the response, compare outputs at the falling
   // edge, advance the model, then move to just after the rising edge.
   task automatic step();
      bit      exp_rv, exp_iv, acc, deq;
      flight_t f;
      entry_t  e;
      mem_t    m;
      int      due;
      drive_rsp();
      @(negedge clk);
      exp_rv = m_started && rstn && (infl.size() < MO)
            && ((infl.size() + iq.size()) < QD) && !redirect;
      exp_iv = (iq.size() > 0);
      check("req_valid", 32'(req_valid), 32'(exp_rv));
      check("req_addr", req_addr, m_pc);
      check("inst_valid", 32'(inst_valid), 32'(exp_iv));
      if (exp_iv) begin
         check("inst", inst, iq[0].data);
         check("inst_pc", inst_pc, iq[0].pc);
      end else if (!rstn) begin
         check("inst_in_reset", inst, 32'h0);
         check("inst_pc_in_reset", inst_pc, 32'h0);
      end
      if (!rstn) begin
         model_reset();
         if (from_mem) void'(mem_q.pop_front());
      end else begin
         acc = exp_rv && req_ready;
         deq = exp_iv && !freeze && !redirect;
         if (deq) void'(iq.pop_front());
         if (rsp_valid && infl.size() > 0) begin
            f = infl.pop_front();
            if (!f.stale && !redirect) begin
               e.data = rsp_data;
               e.pc   = f.pc;
               iq.push_back(e);
            end
         end
         if (from_mem) void'(mem_q.pop_front());
         if (acc) begin
            f.pc    = m_pc;
            f.stale = 1'b0;
            infl.push_back(f);
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m.addr = m_pc;
            m.due  = due;
            mem_q.push_back(m);
            m_pc = m_pc + 32'd4;
         end
         if (redirect) begin
            iq.delete();
            for (int i = 0; i < infl.size(); i++) infl[i].stale = 1'b1;
            m_pc = redirect_pc;
         end
         m_started = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Bounded wait for the DUT to present an instruction, then check its PC.
   task automatic wait_inst(input string tag, input logic [31:0] exp_pc);
      for (int i = 0; i < 40; i++) begin
         if (inst_valid) break;
         step();
      end
      check(tag, inst_valid ? inst_pc : 32'hDEAD_BEEF, exp_pc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(req_valid), 32'h0);
      check({tag, "_req_addr"}, req_addr, RPC);
      check({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
      check({tag, "_inst"}, inst, 32'h0);
      check({tag, "_inst_pc"}, inst_pc, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rstn        = 1'b0;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_data    = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      freeze      = 1'b0;
      model_reset();
      cyc = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");

      // Boot with a one-cycle memory: sequential fetch, first instruction in cycle 3.
      rstn      = 1'b1;
      req_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("boot_inst_valid", 32'(inst_valid), 32'(k >= 3));
         if (k >= 1 && k <= 4) begin
            check("boot_req_valid", 32'(req_valid), 32'h1);
            check("boot_req_addr", req_addr, 32'(4 * (k - 1)));
         end
         if (k == 3) check("boot_first_pc", inst_pc, RPC);
         step();
      end
      repeat (20) step();

      // Consumer frozen: queue fills, fetching stops, then drains in order.
      freeze = 1'b1;
      repeat (10) step();
      check("freeze_req_valid", 32'(req_valid), 32'h0);
      check("freeze_inst_valid", 32'(inst_valid), 32'h1);
      exp_pc0 = iq[0].pc;
      freeze  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("unfreeze_valid", 32'(inst_valid), 32'h1);
         check("unfreeze_pc", inst_pc, exp_pc0 + 32'(4 * k));
         step();
      end

      // Redirect with two requests in flight.
      lat_min = 3;
      lat_max = 3;
      for (int i = 0; i < 20 && infl.size() != 2; i++) step();
      check("outst2_reached", 32'(infl.size()), 32'd2);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      step();
      redirect = 1'b0;
      wait_inst("redir_first_pc", 32'h0000_0100);

      // Redirect in the same cycle as a response.
      lat_min = 2;
      lat_max = 2;
      for (int i = 0; i < 20; i++) begin
         if (mem_q.size() > 0 && mem_q[0].due <= cyc && infl.size() > 0) break;
         step();
      end
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      wait_inst("redir_rsp_first_pc", 32'h0000_0200);

      // Back-to-back redirects: the last one wins.
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      step();
      redirect_pc = 32'h0000_0400;
      step();
      redirect = 1'b0;
      wait_inst("redir_b2b_first_pc", 32'h0000_0400);

      // Spurious responses with nothing outstanding.
      req_ready = 1'b0;
      for (int i = 0; i < 20 && mem_q.size() > 0; i++) step();
      stray_en  = 1'b1;
      stray_mod = 0;
      repeat (4) step();
      stray_mod = 5;

      // Random traffic against the reference stream.
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 200; i++) begin
         req_ready   = 1'($urandom_range(0, 1));
         freeze      = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = 32'h0000_1000 + 32'($urandom_range(0, 255) << 2);
         step();
      end
      redirect = 1'b0;
      freeze   = 1'b0;
      stray_en = 1'b0;

      // Asynchronous reset with two requests in flight; late responses ignored.
      req_ready = 1'b1;
      lat_min   = 3;
      lat_max   = 3;
      for (int i = 0; i < 30 && infl.size() != 2; i++) step();
      check("pre_reset_outst2", 32'(infl.size()), 32'd2);
      rstn = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      #1;
      repeat (2) step();
      rstn      = 1'b1;
      req_ready = 1'b0;
      for (int i = 0; i < 20 && mem_q.size() > 0; i++) step();
      check("late_rsp_ignored", 32'(inst_valid), 32'h0);
      check("restart_addr", req_addr, RPC);
      req_ready = 1'b1;
      lat_min   = 1;
      lat_max   = 1;
      wait_inst("restart_first_pc", RPC);
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
